// File: rtl/debug_trace_buf_if.sv
// Probe/trace bus between the CPU datapath probes, the debug/PDU side and the
// trace buffer. The master side drives probes, selects and controls; the
// slave side (debug_trace_buf) returns live data, trace data and status.
interface debug_trace_buf_if #(
    parameter int NUM_CH = 32,
    parameter int DW     = 32,
    parameter int SEL_W  = 5,
    parameter int AW     = 4
) ();
    logic [NUM_CH*DW-1:0] probe_bus;
    logic [SEL_W-1:0]     check_addr;
    logic [DW-1:0]        check_data;
    logic                 sample_en;
    logic [SEL_W-1:0]     cap_sel;
    logic [SEL_W-1:0]     trig_sel;
    logic [DW-1:0]        trig_val;
    logic [DW-1:0]        trig_mask;
    logic                 arm;
    logic                 disarm;
    logic [AW-1:0]        rd_idx;
    logic [DW-1:0]        trace_rdata;
    logic                 armed;
    logic                 triggered;
    logic                 done;
    logic [AW:0]          trace_cnt;
    logic [AW-1:0]        trig_pos;

    modport master (
        output probe_bus, check_addr, sample_en, cap_sel, trig_sel,
               trig_val, trig_mask, arm, disarm, rd_idx,
        input  check_data, trace_rdata, armed, triggered, done,
               trace_cnt, trig_pos
    );

    modport slave (
        input  probe_bus, check_addr, sample_en, cap_sel, trig_sel,
               trig_val, trig_mask, arm, disarm, rd_idx,
        output check_data, trace_rdata, armed, triggered, done,
               trace_cnt, trig_pos
    );
endinterface

// File: rtl/debug_trace_buf.sv
// Debug trace buffer: combinational live view of one probe channel plus a
// triggered circular trace RAM. An IDLE/ARMED/POST/DONE FSM records one
// selected channel per enabled cycle and freezes the buffer POST_CNT samples
// after the trigger sample.
module debug_trace_buf #(
    parameter int NUM_CH   = 32,
    parameter int DW       = 32,
    parameter int DEPTH    = 16,
    parameter int POST_CNT = 4,
    parameter int SEL_W    = 5
) (
    input  logic            clk,
    input  logic            rst,
    debug_trace_buf_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW-1:0] POST_INIT = AW'(POST_CNT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_POST,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [AW-1:0]   r_wr_ptr;
    logic [AW:0]     r_cnt;
    logic [AW-1:0]   r_post;
    logic [AW-1:0]   r_trig_addr;
    logic [DW-1:0]   r_rdata;
    logic [DW-1:0]   r_mem [DEPTH];

    logic [DW-1:0]   w_live;
    logic [DW-1:0]   w_cap;
    logic [DW-1:0]   w_trg;
    logic            w_hit;
    logic            w_we;
    logic            w_clear;
    logic            w_latch_trig;
    logic            w_post_load;
    logic            w_post_dec;
    logic [AW-1:0]   w_base;
    logic [AW-1:0]   w_rd_addr;

    // Channel extraction; selects at or beyond NUM_CH read as zero.
    function automatic logic [DW-1:0] f_chan(
        input logic [SEL_W-1:0]     sel,
        input logic [NUM_CH*DW-1:0] vec
    );
        logic [DW-1:0] v;
        v = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (32'(sel) == k) begin
                v = vec[k*DW +: DW];
            end
        end
        return v;
    endfunction

    // Live view, capture channel, trigger channel and trigger compare.
    always_comb begin
        w_live = f_chan(bus.check_addr, bus.probe_bus);
        w_cap  = f_chan(bus.cap_sel, bus.probe_bus);
        w_trg  = f_chan(bus.trig_sel, bus.probe_bus);
        w_hit  = (((w_trg ^ bus.trig_val) & bus.trig_mask) == '0);
    end

    // FSM state register; reset aborts any capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and capture controls; disarm beats arm, arm beats capture.
    always_comb begin
        w_state_nxt  = r_state;
        w_we         = 1'b0;
        w_clear      = 1'b0;
        w_latch_trig = 1'b0;
        w_post_load  = 1'b0;
        w_post_dec   = 1'b0;
        if (bus.disarm) begin
            w_state_nxt = S_IDLE;
        end else if (bus.arm) begin
            w_state_nxt = S_ARMED;
            w_clear     = 1'b1;
        end else begin
            case (r_state)
                S_ARMED: begin
                    if (bus.sample_en) begin
                        w_we = 1'b1;
                        if (w_hit) begin
                            w_latch_trig = 1'b1;
                            if (POST_CNT == 0) begin
                                w_state_nxt = S_DONE;
                            end else begin
                                w_state_nxt = S_POST;
                                w_post_load = 1'b1;
                            end
                        end
                    end
                end
                S_POST: begin
                    if (bus.sample_en) begin
                        w_we       = 1'b1;
                        w_post_dec = 1'b1;
                        if (r_post == PTR_ONE) begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    // Write pointer, fill count, post-trigger countdown and trigger address.
    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_wr_ptr    <= '0;
            r_cnt       <= '0;
            r_post      <= '0;
            r_trig_addr <= '0;
        end else begin
            if (w_we) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (r_cnt != CNT_FULL) begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end
            if (w_latch_trig) begin
                r_trig_addr <= r_wr_ptr;
            end
            if (w_post_load) begin
                r_post <= POST_INIT;
            end else if (w_post_dec) begin
                r_post <= r_post - PTR_ONE;
            end
        end
    end

    // Trace RAM write port; no reset so it maps onto RAM primitives.
    always_ff @(posedge clk) begin
        if (w_we && !rst) begin
            r_mem[r_wr_ptr] <= w_cap;
        end
    end

    // Oldest-entry base and read address; once full, the oldest is at wr_ptr.
    always_comb begin
        w_base    = (r_cnt == CNT_FULL) ? r_wr_ptr : '0;
        w_rd_addr = w_base + bus.rd_idx;
    end

    // Registered read port, one cycle latency, readable in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[w_rd_addr];
        end
    end

    // Status and data outputs.
    always_comb begin
        bus.check_data  = w_live;
        bus.trace_rdata = r_rdata;
        bus.armed       = (r_state == S_ARMED);
        bus.triggered   = (r_state == S_POST) || (r_state == S_DONE);
        bus.done        = (r_state == S_DONE);
        bus.trace_cnt   = r_cnt;
        bus.trig_pos    = r_trig_addr - w_base;
    end
endmodule

// File: tb/tb_debug_trace_buf.sv
// Testbench for debug_trace_buf: directed scenarios plus randomized traffic
// checked against a queue-based reference of the trace buffer.
module tb_debug_trace_buf;
    localparam int NUM_CH = 29;
    localparam int DW     = 32;
    localparam int DEPTH  = 8;
    localparam int SEL_W  = 5;
    localparam int AW     = 3;
    localparam int POST_A = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    debug_trace_buf_if #(.NUM_CH(NUM_CH), .DW(DW), .SEL_W(SEL_W), .AW(AW)) ifa ();
    debug_trace_buf_if #(.NUM_CH(NUM_CH), .DW(DW), .SEL_W(SEL_W), .AW(AW)) ifb ();

    debug_trace_buf #(.NUM_CH(NUM_CH), .DW(DW), .DEPTH(DEPTH), .POST_CNT(POST_A), .SEL_W(SEL_W))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    debug_trace_buf #(.NUM_CH(NUM_CH), .DW(DW), .DEPTH(DEPTH), .POST_CNT(0), .SEL_W(SEL_W))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of instance A: the list of stored samples, oldest first.
    logic [DW-1:0] m_q[$];
    bit m_active = 0;
    bit m_trig   = 0;
    bit m_done   = 0;
    int m_post_left = 0;
    int m_writes    = 0;
    int m_trig_n    = 0;

    function automatic logic [DW-1:0] ref_chan(input logic [NUM_CH*DW-1:0] v, input int sel);
        if (sel >= NUM_CH) return '0;
        return v[sel*DW +: DW];
    endfunction

    task automatic model_step();
        logic [DW-1:0] cv;
        logic [DW-1:0] tv;
        if (rst) begin
            m_q.delete(); m_active = 0; m_trig = 0; m_done = 0;
            m_writes = 0; m_trig_n = 0; m_post_left = 0;
        end else if (ifa.disarm) begin
            m_active = 0; m_trig = 0; m_done = 0;
        end else if (ifa.arm) begin
            m_q.delete(); m_writes = 0; m_trig_n = 0;
            m_active = 1; m_trig = 0; m_done = 0;
        end else if (m_active && !m_done && ifa.sample_en) begin
            cv = ref_chan(ifa.probe_bus, int'(ifa.cap_sel));
            tv = ref_chan(ifa.probe_bus, int'(ifa.trig_sel));
            m_q.push_back(cv);
            m_writes++;
            if (m_q.size() > DEPTH) void'(m_q.pop_front());
            if (!m_trig) begin
                if (((tv ^ ifa.trig_val) & ifa.trig_mask) == '0) begin
                    m_trig = 1;
                    m_trig_n = m_writes - 1;
                    m_post_left = POST_A;
                    if (m_post_left == 0) m_done = 1;
                end
            end else begin
                m_post_left--;
                if (m_post_left == 0) m_done = 1;
            end
        end
    endtask

    task automatic tick_a();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_probe_a(input logic [DW-1:0] ch3);
        for (int k = 0; k < NUM_CH; k++) ifa.probe_bus[k*DW +: DW] = $urandom;
        ifa.probe_bus[3*DW +: DW] = ch3;
    endtask

    // Counter on ch3 triggers the capture; optional 5-cycle sample_en gap in POST.
    task automatic run_count(input logic [DW-1:0] tv, input bit gap,
                             output int cyc, output logic [DW-1:0] last);
        int gap_left;
        logic [DW-1:0] cnt;
        gap_left = gap ? 5 : 0;
        cnt = '0;
        ifa.cap_sel = 5'd3; ifa.trig_sel = 5'd3;
        ifa.trig_val = tv; ifa.trig_mask = '1; ifa.sample_en = 1'b1;
        set_probe_a('1);
        ifa.arm = 1'b1;
        tick_a();
        ifa.arm = 1'b0;
        cyc = 0;
        last = '0;
        while (cyc < 100 && !ifa.done) begin
            set_probe_a(cnt);
            if (gap_left > 0 && ifa.triggered) begin
                ifa.sample_en = 1'b0;
                gap_left--;
            end else begin
                ifa.sample_en = 1'b1;
            end
            last = cnt;
            tick_a();
            cyc++;
            cnt++;
        end
        ifa.sample_en = 1'b0;
        n_checks++;
        if (ifa.done !== 1'b1) begin
            n_fail++;
            $display("FAIL capture_timeout: done=%b after %0d cycles, required 1", ifa.done, cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick_a();
        tick_a();
        n_checks++;
        if ({ifa.armed, ifa.triggered, ifa.done, ifb.armed, ifb.triggered, ifb.done} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: a=%b%b%b b=%b%b%b required all 0",
                     ifa.armed, ifa.triggered, ifa.done, ifb.armed, ifb.triggered, ifb.done);
        end
        n_checks++;
        if (ifa.trace_cnt !== 4'd0 || ifb.trace_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: a=%0d b=%0d required 0", ifa.trace_cnt, ifb.trace_cnt);
        end
        n_checks++;
        if (ifa.trace_rdata !== 32'd0 || ifb.trace_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_rdata: a=%h b=%h required 0", ifa.trace_rdata, ifb.trace_rdata);
        end
        n_checks++;
        if (ifa.trig_pos !== 3'd0 || ifb.trig_pos !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_trig_pos: a=%0d b=%0d required 0", ifa.trig_pos, ifb.trig_pos);
        end
        rst = 1'b0;
    endtask

    task automatic test_live_view();
        logic [DW-1:0] exp;
        int a;
        set_probe_a($urandom);
        ifa.check_addr = 5'd7;
        #1;
        n_checks++;
        if (ifa.check_data !== ifa.probe_bus[7*DW +: DW]) begin
            n_fail++;
            $display("FAIL live_ch7: got %h required %h", ifa.check_data, ifa.probe_bus[7*DW +: DW]);
        end
        ifa.check_addr = 5'd30;
        #1;
        n_checks++;
        if (ifa.check_data !== 32'd0) begin
            n_fail++;
            $display("FAIL live_out_of_range: got %h required 0", ifa.check_data);
        end
        for (int i = 0; i < 12; i++) begin
            set_probe_a($urandom);
            a = $urandom_range(0, 31);
            ifa.check_addr = 5'(a);
            #1;
            exp = ref_chan(ifa.probe_bus, a);
            n_checks++;
            if (ifa.check_data !== exp) begin
                n_fail++;
                $display("FAIL live_rand addr=%0d: got %h required %h", a, ifa.check_data, exp);
            end
        end
    endtask

    task automatic test_trigger_late();
        int cyc;
        logic [DW-1:0] last;
        run_count(32'd20, 1'b0, cyc, last);
        n_checks++;
        if (cyc != 24 || last !== 32'd23) begin
            n_fail++;
            $display("FAIL late_done_time: cycles=%0d last=%0d required 24/23", cyc, last);
        end
        n_checks++;
        if (ifa.trace_cnt !== 4'd8) begin
            n_fail++;
            $display("FAIL late_cnt: got %0d required 8", ifa.trace_cnt);
        end
        n_checks++;
        if (ifa.trig_pos !== 3'd4) begin
            n_fail++;
            $display("FAIL late_trig_pos: got %0d required 4", ifa.trig_pos);
        end
        for (int i = 0; i < 8; i++) begin
            ifa.rd_idx = 3'(i);
            tick_a();
            n_checks++;
            if (ifa.trace_rdata !== 32'(16 + i)) begin
                n_fail++;
                $display("FAIL late_read[%0d]: got %0d required %0d", i, ifa.trace_rdata, 16 + i);
            end
        end
    endtask

    task automatic test_trigger_early();
        int cyc;
        logic [DW-1:0] last;
        run_count(32'd2, 1'b0, cyc, last);
        n_checks++;
        if (cyc != 6) begin
            n_fail++;
            $display("FAIL early_done_time: cycles=%0d required 6", cyc);
        end
        n_checks++;
        if (ifa.trace_cnt !== 4'd6) begin
            n_fail++;
            $display("FAIL early_cnt: got %0d required 6", ifa.trace_cnt);
        end
        n_checks++;
        if (ifa.trig_pos !== 3'd2) begin
            n_fail++;
            $display("FAIL early_trig_pos: got %0d required 2", ifa.trig_pos);
        end
        for (int i = 0; i < 6; i++) begin
            ifa.rd_idx = 3'(i);
            tick_a();
            n_checks++;
            if (ifa.trace_rdata !== 32'(i)) begin
                n_fail++;
                $display("FAIL early_read[%0d]: got %0d required %0d", i, ifa.trace_rdata, i);
            end
        end
    endtask

    task automatic test_en_gap();
        int cyc;
        logic [DW-1:0] last;
        run_count(32'd20, 1'b1, cyc, last);
        n_checks++;
        if (cyc != 29) begin
            n_fail++;
            $display("FAIL gap_done_time: cycles=%0d required 29", cyc);
        end
        n_checks++;
        if (ifa.trace_cnt !== 4'd8 || ifa.trig_pos !== 3'd4) begin
            n_fail++;
            $display("FAIL gap_cnt_pos: cnt=%0d pos=%0d required 8/4", ifa.trace_cnt, ifa.trig_pos);
        end
        for (int i = 0; i < m_q.size(); i++) begin
            ifa.rd_idx = 3'(i);
            tick_a();
            n_checks++;
            if (ifa.trace_rdata !== m_q[i]) begin
                n_fail++;
                $display("FAIL gap_read[%0d]: got %0d required %0d", i, ifa.trace_rdata, m_q[i]);
            end
        end
    endtask

    task automatic test_post0();
        logic [DW-1:0] exp;
        ifb.cap_sel = 5'($urandom_range(0, 28));
        ifb.trig_sel = 5'd3;
        ifb.trig_val = $urandom;
        ifb.trig_mask = '0;
        ifb.sample_en = 1'b1;
        ifb.arm = 1'b1;
        tick_a();
        ifb.arm = 1'b0;
        n_checks++;
        if (ifb.armed !== 1'b1 || ifb.done !== 1'b0) begin
            n_fail++;
            $display("FAIL post0_armed: armed=%b done=%b required 1/0", ifb.armed, ifb.done);
        end
        for (int k = 0; k < NUM_CH; k++) ifb.probe_bus[k*DW +: DW] = $urandom;
        exp = ref_chan(ifb.probe_bus, int'(ifb.cap_sel));
        tick_a();
        ifb.sample_en = 1'b0;
        n_checks++;
        if (ifb.done !== 1'b1 || ifb.triggered !== 1'b1 || ifb.trace_cnt !== 4'd1 || ifb.trig_pos !== 3'd0) begin
            n_fail++;
            $display("FAIL post0_done: done=%b trig=%b cnt=%0d pos=%0d required 1/1/1/0",
                     ifb.done, ifb.triggered, ifb.trace_cnt, ifb.trig_pos);
        end
        ifb.rd_idx = '0;
        tick_a();
        n_checks++;
        if (ifb.trace_rdata !== exp) begin
            n_fail++;
            $display("FAIL post0_read: got %h required %h", ifb.trace_rdata, exp);
        end
    endtask

    task automatic test_arm_disarm();
        ifa.cap_sel = 5'd3; ifa.trig_sel = 5'd3;
        ifa.trig_val = '1; ifa.trig_mask = '1; ifa.sample_en = 1'b0;
        ifa.arm = 1'b1;
        tick_a();
        ifa.arm = 1'b0;
        ifa.sample_en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            set_probe_a(32'(i));
            tick_a();
        end
        ifa.sample_en = 1'b0;
        ifa.arm = 1'b1;
        ifa.disarm = 1'b1;
        tick_a();
        ifa.arm = 1'b0;
        ifa.disarm = 1'b0;
        n_checks++;
        if ({ifa.armed, ifa.triggered, ifa.done} !== 3'b000) begin
            n_fail++;
            $display("FAIL armdis_idle: flags=%b%b%b required 000", ifa.armed, ifa.triggered, ifa.done);
        end
        ifa.sample_en = 1'b1;
        tick_a();
        tick_a();
        tick_a();
        ifa.sample_en = 1'b0;
        n_checks++;
        if (ifa.trace_cnt !== 4'd8) begin
            n_fail++;
            $display("FAIL armdis_cnt: got %0d required 8", ifa.trace_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            ifa.rd_idx = 3'(i);
            tick_a();
            n_checks++;
            if (ifa.trace_rdata !== 32'(3 + i)) begin
                n_fail++;
                $display("FAIL armdis_read[%0d]: got %0d required %0d", i, ifa.trace_rdata, 3 + i);
            end
        end
        rst = 1'b1;
        tick_a();
        rst = 1'b0;
        n_checks++;
        if (ifa.trace_cnt !== 4'd0 || ifa.trace_rdata !== 32'd0 ||
            {ifa.armed, ifa.triggered, ifa.done} !== 3'b000 || ifa.trig_pos !== 3'd0) begin
            n_fail++;
            $display("FAIL armdis_rst: cnt=%0d rdata=%h flags=%b%b%b pos=%0d required all 0",
                     ifa.trace_cnt, ifa.trace_rdata, ifa.armed, ifa.triggered, ifa.done, ifa.trig_pos);
        end
    endtask

    task automatic test_random();
        int r;
        int e_pos;
        bit rb_done;
        logic [AW-1:0] e_pos_v;
        rb_done = 0;
        for (int c = 0; c < 500; c++) begin
            r = $urandom_range(0, 99);
            ifa.arm = (r < 6);
            ifa.disarm = (r >= 97);
            rst = (r == 50);
            if (ifa.arm) begin
                ifa.trig_val = $urandom;
                ifa.trig_mask = $urandom & 32'h0000_003F;
                ifa.trig_sel = 5'($urandom_range(0, 31));
                rb_done = 0;
            end
            ifa.sample_en = ($urandom_range(0, 3) != 0);
            ifa.cap_sel = 5'($urandom_range(0, 31));
            set_probe_a($urandom);
            tick_a();
            ifa.arm = 1'b0;
            ifa.disarm = 1'b0;
            rst = 1'b0;
            n_checks++;
            if (ifa.armed !== (m_active && !m_trig && !m_done) || ifa.triggered !== m_trig ||
                ifa.done !== m_done) begin
                n_fail++;
                $display("FAIL rand_flags c=%0d: got %b%b%b required %b%b%b", c,
                         ifa.armed, ifa.triggered, ifa.done, m_active && !m_trig && !m_done, m_trig, m_done);
            end
            n_checks++;
            if (ifa.trace_cnt !== 4'(m_q.size())) begin
                n_fail++;
                $display("FAIL rand_cnt c=%0d: got %0d required %0d", c, ifa.trace_cnt, m_q.size());
            end
            if (m_done && !rb_done) begin
                e_pos = m_trig_n - (m_writes - m_q.size());
                e_pos_v = e_pos[AW-1:0];
                n_checks++;
                if (ifa.trig_pos !== e_pos_v) begin
                    n_fail++;
                    $display("FAIL rand_trig_pos c=%0d: got %0d required %0d", c, ifa.trig_pos, e_pos_v);
                end
                for (int i = 0; i < m_q.size(); i++) begin
                    ifa.rd_idx = 3'(i);
                    tick_a();
                    n_checks++;
                    if (ifa.trace_rdata !== m_q[i]) begin
                        n_fail++;
                        $display("FAIL rand_read[%0d] c=%0d: got %h required %h", i, c, ifa.trace_rdata, m_q[i]);
                    end
                end
                rb_done = 1;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        ifa.probe_bus = '0; ifa.check_addr = '0; ifa.sample_en = 1'b0; ifa.cap_sel = '0;
        ifa.trig_sel = '0; ifa.trig_val = '0; ifa.trig_mask = '0; ifa.arm = 1'b0;
        ifa.disarm = 1'b0; ifa.rd_idx = '0;
        ifb.probe_bus = '0; ifb.check_addr = '0; ifb.sample_en = 1'b0; ifb.cap_sel = '0;
        ifb.trig_sel = '0; ifb.trig_val = '0; ifb.trig_mask = '0; ifb.arm = 1'b0;
        ifb.disarm = 1'b0; ifb.rd_idx = '0;
        test_reset();
        test_live_view();
        test_trigger_late();
        test_trigger_early();
        test_en_gap();
        test_post0();
        test_arm_disarm();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/debug_trace_buf.md
Name: debug_trace_buf

Overview:
- Parametrised successor to the CPU debug-check mux.
- Keeps the combinational live-select of one probe channel: any channel, any width.
- Adds a triggered trace buffer. One selected channel is sampled into a circular RAM each enabled cycle. An armed/trigger/post-trigger FSM freezes the buffer around an event.
- Sits between the CPU datapath probe bus and the board debug/PDU interface.

Parameters:
NUM_CH, 32, number of probe channels on probe_bus
DW, 32, width of each channel in bits
DEPTH, 16, trace entries; power of two, >= 2
POST_CNT, 4, samples stored after the trigger sample; legal range 0..DEPTH-1
SEL_W, 5, channel-select width; must satisfy 2**SEL_W >= NUM_CH
AW, log2(DEPTH), local, trace pointer width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
probe_bus  in  NUM_CH*DW  channel k occupies bits [k*DW +: DW]
check_addr  in  SEL_W  live-view channel select
check_data  out  DW  live-view data (combinational)
sample_en  in  1  sampling/trigger qualifier (low while CPU is halted)
cap_sel  in  SEL_W  channel written into the trace RAM
trig_sel  in  SEL_W  channel compared for trigger
trig_val  in  DW  trigger compare value
trig_mask  in  DW  compare mask; 1 = bit participates
arm  in  1  single-cycle pulse: start/restart capture
disarm  in  1  single-cycle pulse: stop capture, go idle
rd_idx  in  AW  read index, 0 = oldest valid entry
trace_rdata  out  DW  registered read data
armed  out  1  FSM in ARMED
triggered  out  1  FSM in POST or DONE
done  out  1  FSM in DONE
trace_cnt  out  AW+1  valid entries, saturates at DEPTH
trig_pos  out  AW  read index (oldest-relative) of the trigger sample; valid when done

Behaviour:
- Live mux: check_data = channel check_addr. If check_addr >= NUM_CH, check_data = 0. Purely combinational.
- Capture and trigger channels use the same out-of-range rule (value 0).
- Trigger hit = ((chan[trig_sel] ^ trig_val) & trig_mask) == 0. trig_mask = 0 therefore triggers on the first enabled sample.
- FSM states: IDLE, ARMED, POST, DONE. Registered; one transition per clk.
- A write occurs only in ARMED or POST with sample_en = 1. It stores chan[cap_sel] at wr_ptr. wr_ptr then increments mod DEPTH, and trace_cnt increments, saturating at DEPTH.
- IDLE, arm -> ARMED. wr_ptr, trace_cnt and post counter clear to 0.
- ARMED, sample_en & hit -> the current sample is written; the trigger pointer is latched to the written address. Then:
  - POST_CNT = 0 -> DONE.
  - otherwise -> POST, post counter = POST_CNT.
- ARMED, sample_en & !hit -> write and stay; the buffer overwrites circularly.
- POST, sample_en -> write and decrement the post counter. When it reaches 0 after this write -> DONE.
- sample_en = 0 in POST: no write, no decrement.
- DONE: no writes. Buffer frozen until arm, disarm or rst.
- arm in ARMED/POST/DONE restarts exactly as from IDLE. The sample in that cycle is not written.
- disarm in any state -> IDLE. Memory and trace_cnt are retained and remain readable.
- arm and disarm in the same cycle: disarm wins.
- Read path:
  - Oldest entry address is base = (trace_cnt == DEPTH) ? wr_ptr : 0.
  - trace_rdata <= mem[(base + rd_idx) mod DEPTH], one cycle latency. Valid in every state.
  - rd_idx >= trace_cnt returns stale/undefined data; the bench must not check it.
- trig_pos = (trigger address - base) mod DEPTH, using base at the time of reading.
- Reset (sync, highest priority over arm/disarm):
  - Outputs: state IDLE, trace_rdata = 0, trace_cnt = 0, trig_pos = 0, armed/triggered/done = 0.
  - Internal: wr_ptr = 0, post counter = 0.
  - Trace RAM contents are not reset; must map to distributed/block RAM.
- Reset mid-capture aborts immediately to IDLE.
- All pointer arithmetic is AW-bit wrap-around; trace_cnt is AW+1 bits.

Test Plan:
- DEPTH=8, POST_CNT=3. probe ch3 = cycle counter starting at 0; cap_sel=3, trig_sel=3, trig_val=20, mask=all-ones; arm at counter 0, sample_en=1. Required: done after counter 23; trace_cnt=8; reads idx0..7 = 16..23; trig_pos=4.
- Same setup, trig_val=2. Required: done with trace_cnt=6; idx0..5 = 0..5 (each read one cycle after rd_idx); trig_pos=2.
- POST_CNT=0, mask=0. Required: DONE one cycle after arm; trace_cnt=1; idx0 = first sample; trig_pos=0.
- Drop sample_en for 5 cycles during POST. Required: no writes or decrements while low; done is delayed by exactly 5 cycles.
- Pulse arm and disarm together while ARMED. Required: FSM goes to IDLE; data is retained. A later rst clears trace_cnt/flags/trace_rdata to 0 on the next edge.
- Live view: check_addr = 7 -> check_data = ch7. With NUM_CH=29, check_addr = 30 -> check_data = 0.
